// File: rtl/im_addr_seq.sv
// rtl/im_addr_seq.sv - burst address sequencer issuing item-memory port A/B tuples
module im_addr_seq #(
  parameter int HVDimension = 512,
  parameter int NumTotIm    = 1024,
  parameter int ImAddrWidth = 32,
  parameter int CountWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_port_a_cim_i,
  input  logic [ImAddrWidth-1:0] cfg_a_start_i,
  input  logic [ImAddrWidth-1:0] cfg_a_stride_i,
  input  logic [ImAddrWidth-1:0] cfg_b_start_i,
  input  logic [ImAddrWidth-1:0] cfg_b_stride_i,
  input  logic [CountWidth-1:0]  cfg_num_items_i,
  input  logic                   start_i,
  input  logic                   clear_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   addr_valid_o,
  input  logic                   addr_ready_i,
  output logic                   port_a_cim_o,
  output logic [ImAddrWidth-1:0] im_a_addr_o,
  output logic [ImAddrWidth-1:0] im_b_addr_o,
  output logic                   last_o
);

  localparam int CimSelWidth = $clog2(HVDimension / 2);
  localparam int ImSelWidth  = $clog2(NumTotIm);

  // Address-space masks; wrap-around falls out of masking the sum
  localparam logic [ImAddrWidth-1:0] CimMask =
    {{(ImAddrWidth - CimSelWidth){1'b0}}, {CimSelWidth{1'b1}}};
  localparam logic [ImAddrWidth-1:0] ImMask =
    {{(ImAddrWidth - ImSelWidth){1'b0}}, {ImSelWidth{1'b1}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   cim_mode;
  logic [ImAddrWidth-1:0] a_addr;
  logic [ImAddrWidth-1:0] b_addr;
  logic [ImAddrWidth-1:0] a_stride;
  logic [ImAddrWidth-1:0] b_stride;
  logic [CountWidth-1:0]  count;
  logic                   done;

  logic                   load;
  logic                   advance;
  logic                   finish;
  logic                   abort;
  logic                   done_next;
  logic                   count_is_one;
  logic [ImAddrWidth-1:0] a_mask;
  logic [ImAddrWidth-1:0] cfg_a_mask;

  assign count_is_one = (count == CountWidth'(1));
  assign a_mask       = cim_mode ? CimMask : ImMask;
  assign cfg_a_mask   = cfg_port_a_cim_i ? CimMask : ImMask;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and datapath control; clear wins over start and over a transfer
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_i) begin
          abort = 1'b1;
        end else if (start_i) begin
          if (cfg_num_items_i != '0) begin
            load       = 1'b1;
            state_next = RUN;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (clear_i) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (addr_ready_i) begin
          if (count_is_one) begin
            finish     = 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst configuration, address registers and item counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cim_mode <= 1'b0;
      a_addr   <= '0;
      b_addr   <= '0;
      a_stride <= '0;
      b_stride <= '0;
      count    <= '0;
    end else if (abort || finish) begin
      count <= '0;
    end else if (load) begin
      cim_mode <= cfg_port_a_cim_i;
      a_addr   <= cfg_a_start_i & cfg_a_mask;
      b_addr   <= cfg_b_start_i & ImMask;
      a_stride <= cfg_a_stride_i;
      b_stride <= cfg_b_stride_i;
      count    <= cfg_num_items_i;
    end else if (advance) begin
      a_addr <= (a_addr + a_stride) & a_mask;
      b_addr <= (b_addr + b_stride) & ImMask;
      count  <= count - CountWidth'(1);
    end
  end

  // Completion pulse, one cycle after the final transfer or a zero-length start
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done <= 1'b0;
    end else begin
      done <= done_next;
    end
  end

  assign busy_o       = (state == RUN);
  assign addr_valid_o = (state == RUN);
  assign last_o       = (state == RUN) && count_is_one;
  assign done_o       = done;
  assign port_a_cim_o = cim_mode;
  assign im_a_addr_o  = a_addr;
  assign im_b_addr_o  = b_addr;

endmodule

// File: tb/tb_im_addr_seq.sv
// tb/tb_im_addr_seq.sv - self-checking bench for im_addr_seq
module tb_im_addr_seq;

  localparam int AW    = 32;
  localparam int CW    = 16;
  localparam int CIM_W = $clog2(512 / 2);
  localparam int IM_W  = $clog2(1024);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_port_a_cim;
  logic [AW-1:0] cfg_a_start;
  logic [AW-1:0] cfg_a_stride;
  logic [AW-1:0] cfg_b_start;
  logic [AW-1:0] cfg_b_stride;
  logic [CW-1:0] cfg_num_items;
  logic          start;
  logic          clear;
  logic          busy;
  logic          done;
  logic          addr_valid;
  logic          addr_ready;
  logic          port_a_cim;
  logic [AW-1:0] im_a_addr;
  logic [AW-1:0] im_b_addr;
  logic          last;

  int checks = 0;
  int errors = 0;
  bit ready_pat[$];

  typedef struct {
    logic          cim;
    logic [AW-1:0] a_start;
    logic [AW-1:0] a_stride;
    logic [AW-1:0] b_start;
    logic [AW-1:0] b_stride;
    logic [CW-1:0] num;
    int            ready_mode;
    logic [AW-1:0] exp_a_last;
    logic [AW-1:0] exp_b_last;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  im_addr_seq dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_port_a_cim_i(cfg_port_a_cim),
    .cfg_a_start_i   (cfg_a_start),
    .cfg_a_stride_i  (cfg_a_stride),
    .cfg_b_start_i   (cfg_b_start),
    .cfg_b_stride_i  (cfg_b_stride),
    .cfg_num_items_i (cfg_num_items),
    .start_i         (start),
    .clear_i         (clear),
    .busy_o          (busy),
    .done_o          (done),
    .addr_valid_o    (addr_valid),
    .addr_ready_i    (addr_ready),
    .port_a_cim_o    (port_a_cim),
    .im_a_addr_o     (im_a_addr),
    .im_b_addr_o     (im_b_addr),
    .last_o          (last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: the i-th address of a burst is (start + i*stride) mod 2^width
  function automatic logic [AW-1:0] model_addr(input bit cim, input bit is_a,
                                               input logic [AW-1:0] st,
                                               input logic [AW-1:0] stride, input int i);
    int w;
    longint unsigned v;
    w = (is_a && cim) ? CIM_W : IM_W;
    v = 64'(st) + 64'(i) * 64'(stride);
    return AW'(v % (64'd1 << w));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = ready_pat queue then ready
  task automatic run_burst(input bit cim, input logic [AW-1:0] as, input logic [AW-1:0] ast,
                           input logic [AW-1:0] bs, input logic [AW-1:0] bst,
                           input logic [CW-1:0] num, input int ready_mode);
    int idx;
    int cyc;
    bit r;
    cfg_port_a_cim = cim;
    cfg_a_start    = as;
    cfg_a_stride   = ast;
    cfg_b_start    = bs;
    cfg_b_stride   = bst;
    cfg_num_items  = num;
    start          = 1'b1;
    addr_ready     = 1'b0;
    step();
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < int'(num) && cyc < 300) begin
      check("valid", addr_valid, 1);
      check("busy", busy, 1);
      check("done_in_run", done, 0);
      check("cim", port_a_cim, cim);
      check("a_addr", im_a_addr, model_addr(cim, 1'b1, as, ast, idx));
      check("b_addr", im_b_addr, model_addr(cim, 1'b0, bs, bst, idx));
      check("last", last, (idx == int'(num) - 1));
      if (ready_mode == 0) r = 1'b1;
      else if (ready_mode == 1) r = ($urandom_range(0, 2) != 0);
      else if (ready_pat.size() > 0) r = ready_pat.pop_front();
      else r = 1'b1;
      addr_ready = r;
      // Start requests and cfg changes during the burst must be ignored
      start          = $urandom_range(0, 1);
      cfg_port_a_cim = $urandom_range(0, 1);
      cfg_a_start    = $urandom();
      cfg_a_stride   = $urandom();
      cfg_b_start    = $urandom();
      cfg_b_stride   = $urandom();
      cfg_num_items  = CW'($urandom_range(0, 20));
      step();
      cyc++;
      if (r) idx++;
    end
    if (idx < int'(num)) check("burst_timeout", idx, num);
    start      = 1'b0;
    addr_ready = 1'b0;
    check("end_valid", addr_valid, 0);
    check("end_busy", busy, 0);
    check("end_done", done, 1);
    check("end_last", last, 0);
    check("end_a_hold", im_a_addr, model_addr(cim, 1'b1, as, ast, int'(num) - 1));
    check("end_b_hold", im_b_addr, model_addr(cim, 1'b0, bs, bst, int'(num) - 1));
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd5,    32'd1, 32'd100,        32'd2,          16'd4, 0, 32'd8,  32'd106};
    vecs[1] = '{1'b0, 32'd1022, 32'd3, 32'd0,          32'd1,          16'd3, 0, 32'd4,  32'd2};
    vecs[2] = '{1'b1, 32'd250,  32'd4, 32'd7,          32'd5,          16'd3, 0, 32'd2,  32'd17};
    vecs[3] = '{1'b0, 32'd10,   32'd7, 32'd1000,       32'd50,         16'd3, 2, 32'd24, 32'd76};
    vecs[4] = '{1'b0, 32'h0001_0005, 32'd1, 32'hFFFF_FC00, 32'hFFFF_FFFF, 16'd2, 0, 32'd6, 32'd1023};

    rst            = 1'b1;
    cfg_port_a_cim = 1'b0;
    cfg_a_start    = '0;
    cfg_a_stride   = '0;
    cfg_b_start    = '0;
    cfg_b_stride   = '0;
    cfg_num_items  = '0;
    start          = 1'b0;
    clear          = 1'b0;
    addr_ready     = 1'b0;
    #12;
    check("rst_valid", addr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", last, 0);
    check("rst_cim", port_a_cim, 0);
    check("rst_a", im_a_addr, 0);
    check("rst_b", im_b_addr, 0);
    #1 rst = 1'b0;
    step();
    check("idle_valid", addr_valid, 0);

    // Directed bursts from the table
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].ready_mode == 2) begin
        ready_pat.delete();
        ready_pat.push_back(1'b1);
        ready_pat.push_back(1'b0);
        ready_pat.push_back(1'b0);
        ready_pat.push_back(1'b1);
        ready_pat.push_back(1'b1);
      end
      run_burst(vecs[i].cim, vecs[i].a_start, vecs[i].a_stride, vecs[i].b_start,
                vecs[i].b_stride, vecs[i].num, vecs[i].ready_mode);
      check("tbl_a_last", im_a_addr, vecs[i].exp_a_last);
      check("tbl_b_last", im_b_addr, vecs[i].exp_b_last);
      step();
      check("gap_done", done, 0);
      check("gap_valid", addr_valid, 0);
    end

    // Zero-length start: done pulse, no valid
    cfg_num_items = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("zero_valid", addr_valid, 0);
    check("zero_busy", busy, 0);
    check("zero_done", done, 1);
    step();
    check("zero_done_clr", done, 0);
    check("zero_valid2", addr_valid, 0);

    // Clear on the 2nd tuple, coincident with a transfer
    cfg_port_a_cim = 1'b0;
    cfg_a_start    = 32'd40;
    cfg_a_stride   = 32'd3;
    cfg_b_start    = 32'd9;
    cfg_b_stride   = 32'd1;
    cfg_num_items  = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    addr_ready = 1'b1;
    step();
    check("clr_pre_valid", addr_valid, 1);
    check("clr_pre_a", im_a_addr, 43);
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    addr_ready = 1'b0;
    check("clr_valid", addr_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_last", last, 0);
    check("clr_done", done, 0);
    step();
    check("clr_done2", done, 0);
    check("clr_valid2", addr_valid, 0);

    // Asynchronous reset mid-burst
    cfg_port_a_cim = 1'b1;
    cfg_a_start    = 32'd17;
    cfg_a_stride   = 32'd2;
    cfg_b_start    = 32'd300;
    cfg_b_stride   = 32'd4;
    cfg_num_items  = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    addr_ready = 1'b1;
    step();
    check("ar_pre_valid", addr_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", addr_valid, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_last", last, 0);
    check("ar_cim", port_a_cim, 0);
    check("ar_a", im_a_addr, 0);
    check("ar_b", im_b_addr, 0);
    #1 rst = 1'b0;
    addr_ready = 1'b0;
    step();
    check("ar_post_valid", addr_valid, 0);
    check("ar_post_busy", busy, 0);
    run_burst(1'b0, 32'd600, 32'd11, 32'd20, 32'd30, 16'd3, 0);
    step();

    // Randomized bursts, sometimes back-to-back on the done cycle
    for (int n = 0; n < 30; n++) begin
      run_burst($urandom_range(0, 1), $urandom(), $urandom(), $urandom(), $urandom(),
                CW'($urandom_range(1, 6)), 1);
      if ($urandom_range(0, 1) == 1) begin
        step();
        check("rnd_gap_done", done, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
